// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle logic/add/sub/slt ops,
// iterative shift-add MUL and optional restoring DIVU.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready, a, b, op
// request side; out_valid/out_ready, result, hi, zero, err result side.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise DIVU reports err.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic             rdy_st;
    logic             accept;
    logic [WIDTH-1:0] sc_res;
    logic             sc_err;

    // One shift-add step: add multiplicand on multiplier LSB,
    // then shift the {hi,lo} pair right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;

    assign mul_sum  = {1'b0, acc_hi_q}
                    + {1'b0, (acc_lo_q[0] ? opnd_q : '0)};
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    // One restoring step: shift dividend MSB into the partial
    // remainder, subtract divisor when it fits, shift in the
    // quotient bit. Divisor 0 naturally yields q=all ones, r=a.
    logic [WIDTH:0]   div_t;
    logic             div_ge;
    logic [WIDTH-1:0] div_s;
    logic [WIDTH-1:0] div_hi_n;
    logic [WIDTH-1:0] div_lo_n;

    assign div_t    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge   = div_t >= {1'b0, opnd_q};
    assign div_s    = div_t[WIDTH-1:0] - opnd_q;
    assign div_hi_n = div_ge ? div_s : div_t[WIDTH-1:0];
    assign div_lo_n = {acc_lo_q[WIDTH-2:0], div_ge};
`endif

    always_comb begin
        rdy_st = 1'b0;
        unique case (state_q)
            IDLE:    rdy_st = 1'b1;
            DONE:    rdy_st = out_ready;
            default: rdy_st = 1'b0;
        endcase
    end

    // Reset cycles never accept work.
    assign in_ready = rdy_st & rst_n;
    assign accept   = in_valid & in_ready;

    always_comb begin
        sc_res = '0;
        sc_err = 1'b0;
        unique case (op)
            3'b000:  sc_res = a & b;
            3'b001:  sc_res = a | b;
            3'b010:  sc_res = a + b;
            3'b110:  sc_res = a - b;
            3'b111:  sc_res = {{(WIDTH-1){1'b0}},
                               $signed(a) < $signed(b)};
            default: sc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        opnd_d      = opnd_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        hi_d        = hi_q;
        zero_d      = zero_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE: ;
            MUL: begin
                acc_hi_d = mul_hi_n;
                acc_lo_d = mul_lo_n;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = mul_lo_n;
                    hi_d        = mul_hi_n;
                    zero_d      = (mul_lo_n == '0);
                    err_d       = 1'b0;
                end
            end
            DIV: begin
`ifdef ALU_SEQ_DIV_EN
                acc_hi_d = div_hi_n;
                acc_lo_d = div_lo_n;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = div_lo_n;
                    hi_d        = div_hi_n;
                    zero_d      = (div_lo_n == '0);
                    err_d       = (opnd_q == '0);
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    result_d    = '0;
                    hi_d        = '0;
                    zero_d      = 1'b0;
                    err_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept overrides: covers IDLE and retire-plus-accept in DONE.
        if (accept) begin
            out_valid_d = 1'b0;
            result_d    = '0;
            hi_d        = '0;
            zero_d      = 1'b0;
            err_d       = 1'b0;
            acc_hi_d    = '0;
            cnt_d       = CW'(WIDTH - 1);
            if (op == 3'b011) begin
                state_d  = MUL;
                opnd_d   = a;
                acc_lo_d = b;
`ifdef ALU_SEQ_DIV_EN
            end else if (op == 3'b100) begin
                state_d  = DIV;
                opnd_d   = b;
                acc_lo_d = a;
`endif
            end else begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                result_d    = sc_res;
                zero_d      = (sc_res == '0);
                err_d       = sc_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opnd_q      <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            opnd_q      <= opnd_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign hi        = hi_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq at WIDTH=32.
// Each task drives one scenario and checks its own results.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        err;

    int n_tests;
    int n_fail;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .hi        (hi),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o,
                         input logic [31:0] x,
                         input logic [31:0] y);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
    endtask

    task automatic wait_valid(output int c);
        c = 1;
        while (!out_valid && c < 40) begin
            tick();
            c++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        op = '0;
        tick();
        tick();
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_ready: got %b exp 0", in_ready);
        end
        n_tests++;
        if ({out_valid, result, hi, zero, err} !== '0) begin
            n_fail++;
            $display("FAIL rst_outs: got v=%b r=%h h=%h z=%b e=%b exp 0",
                     out_valid, result, hi, zero, err);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready: got %b exp 1", in_ready);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(3'b010, 32'd200, 32'd100);
        tick();
        n_tests++;
        if ({out_valid, result, hi, zero, err} !==
            {1'b1, 32'd300, 32'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add: got v=%b r=%0d h=%0d z=%b e=%b exp 1 300 0 0 0",
                     out_valid, result, hi, zero, err);
        end
        drive(3'b110, 32'd200, 32'd100);
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || result !== 32'd100) begin
            n_fail++;
            $display("FAIL sub: got v=%b r=%0d exp 1 100", out_valid, result);
        end
        drive(3'b111, 32'd100, 32'd200);
        tick();
        n_tests++;
        if (result !== 32'd1) begin
            n_fail++;
            $display("FAIL slt_pos: got %0d exp 1", result);
        end
        drive(3'b111, 32'hFFFF_FFFF, 32'd1);
        tick();
        n_tests++;
        if (result !== 32'd1) begin
            n_fail++;
            $display("FAIL slt_neg: got %0d exp 1", result);
        end
        drive(3'b111, 32'd1, 32'hFFFF_FFFF);
        tick();
        n_tests++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL slt_false: got r=%0d z=%b exp 0 1", result, zero);
        end
        drive(3'b010, 32'hFFFF_FFFF, 32'd1);
        tick();
        n_tests++;
        if ({result, hi, zero} !== {32'd0, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_wrap: got r=%h h=%h z=%b exp 0 0 1",
                     result, hi, zero);
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if ({out_valid, result, zero} !== '0) begin
            n_fail++;
            $display("FAIL idle_after: got v=%b r=%h z=%b exp 0",
                     out_valid, result, zero);
        end
    endtask

    task automatic test_mul();
        int c;
        int bad_rdy;
        out_ready = 1'b1;
        drive(3'b011, 32'hFFFF_FFFF, 32'd2);
        tick();
        // Garbage request held during MUL must be ignored.
        out_ready = 1'b0;
        drive(3'b000, 32'h1234_5678, 32'h0);
        c = 1;
        bad_rdy = 0;
        while (!out_valid && c < 40) begin
            if (in_ready !== 1'b0) bad_rdy++;
            tick();
            c++;
        end
        n_tests++;
        if (bad_rdy != 0) begin
            n_fail++;
            $display("FAIL mul_in_ready: got %0d ready cycles exp 0", bad_rdy);
        end
        n_tests++;
        if (c != 33) begin
            n_fail++;
            $display("FAIL mul_latency: got %0d exp 33", c);
        end
        n_tests++;
        if ({result, hi, err, zero} !==
            {32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_val: got r=%h h=%h e=%b z=%b exp fffffffe 1 0 0",
                     result, hi, err, zero);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_retire: got %b exp 0", out_valid);
        end
    endtask

    task automatic test_div();
        int c;
        out_ready = 1'b1;
`ifdef ALU_SEQ_DIV_EN
        drive(3'b100, 32'd200, 32'd7);
        tick();
        in_valid = 1'b0;
        wait_valid(c);
        n_tests++;
        if (c != 33) begin
            n_fail++;
            $display("FAIL div_latency: got %0d exp 33", c);
        end
        n_tests++;
        if ({result, hi, err} !== {32'd28, 32'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL div_val: got q=%0d r=%0d e=%b exp 28 4 0",
                     result, hi, err);
        end
        drive(3'b100, 32'd5, 32'd0);
        tick();
        in_valid = 1'b0;
        wait_valid(c);
        n_tests++;
        if (c != 33) begin
            n_fail++;
            $display("FAIL div0_latency: got %0d exp 33", c);
        end
        n_tests++;
        if ({result, hi, err} !== {32'hFFFF_FFFF, 32'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL div0_val: got q=%h r=%0d e=%b exp ffffffff 5 1",
                     result, hi, err);
        end
`else
        drive(3'b100, 32'd200, 32'd7);
        tick();
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, result, hi, err} !== {1'b1, 32'd0, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL divu_off: got v=%b r=%h h=%h e=%b exp 1 0 0 1",
                     out_valid, result, hi, err);
        end
        c = 0;
`endif
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        int bad;
        out_ready = 1'b0;
        drive(3'b000, 32'd200, 32'd100);
        tick();
        in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || result !== 32'd64 ||
                zero !== 1'b0 || in_ready !== 1'b0) bad++;
            tick();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold: got %0d bad cycles exp 0 (r=%0d)", bad, result);
        end
        out_ready = 1'b1;
        drive(3'b001, 32'd200, 32'd32);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b exp 1", in_ready);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || result !== 32'd232) begin
            n_fail++;
            $display("FAIL b2b_or: got v=%b r=%0d exp 1 232", out_valid, result);
        end
        drive(3'b110, 32'd200, 32'd100);
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || result !== 32'd100) begin
            n_fail++;
            $display("FAIL b2b_sub: got v=%b r=%0d exp 1 100", out_valid, result);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int c;
        out_ready = 1'b1;
        drive(3'b011, 32'd3, 32'd5);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ready: got %b exp 0", in_ready);
        end
        tick();
        n_tests++;
        if ({out_valid, result, hi, zero, err, in_ready} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outs: got v=%b r=%h h=%h z=%b e=%b rdy=%b exp 0",
                     out_valid, result, hi, zero, err, in_ready);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_release: got %b exp 1", in_ready);
        end
        drive(3'b010, 32'd7, 32'd8);
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || result !== 32'd15) begin
            n_fail++;
            $display("FAIL midrst_add: got v=%b r=%0d exp 1 15", out_valid, result);
        end
        tick();
        wait_valid(c);
        n_tests++;
        if (c != 40) begin
            n_fail++;
            $display("FAIL midrst_stale: got valid at %0d exp none", c);
        end
    endtask

    task automatic test_edge();
        out_ready = 1'b1;
        drive(3'b110, 32'd100, 32'd100);
        tick();
        n_tests++;
        if (result !== 32'd0 || zero !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_zero: got r=%0d z=%b e=%b exp 0 1 0",
                     result, zero, err);
        end
        drive(3'b101, 32'd9, 32'd3);
        tick();
        n_tests++;
        if ({out_valid, result, hi, err} !== {1'b1, 32'd0, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL op101: got v=%b r=%h h=%h e=%b exp 1 0 0 1",
                     out_valid, result, hi, err);
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        test_reset();
        test_single();
        test_mul();
        test_div();
        test_hold();
        test_reset_mid();
        test_edge();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
